// File: rtl/pipe_stage_reg.sv
// Parameterised pipeline register chain with stall, flush and a live count of valid stages.
// Priority on every rising edge: reset, then flush, then stall, then shift.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      DEPTH      = 1,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(32'h0000_0013),
   localparam int unsigned     CW         = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
      data_d  = data_q;
      valid_d = valid_q;
      count_d = count_q;

      if (flush_i) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            data_d[k] = BUBBLE_VAL;
         end
         valid_d = '0;
         count_d = '0;
      end else if (!stall_i) begin
         data_d[0]  = data_i;
         valid_d[0] = valid_i;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
         // Last-stage valid set implies count >= 1, and a full chain only stays full, so no wrap.
         count_d = count_q + CW'(valid_i) - CW'(valid_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the stage payloads are reset too, because RESET_VAL is visible on data_o right after reset.
         for (int unsigned k = 0; k < DEPTH; k++) begin
            data_q[k] <= RESET_VAL;
         end
         valid_q <= '0;
         count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
         data_q  <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign data_o  = data_q[DEPTH-1];
   assign valid_o = valid_q[DEPTH-1];
   assign count_o = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three configurations (3-deep, 4-deep, 1-deep 8-bit).
// Stimulus pushes cycle-tagged expectations; a negedge monitor pops and compares them.
module tb_pipe_stage_reg;

   typedef struct {
      int          cyc;
      int          inst;
      logic [31:0] d;
      logic        v;
      int          c;
      string       tag;
   } exp_t;

   exp_t sb_q [$];
   exp_t mon_e;
   int   cyc    = 0;
   int   ntests = 0;
   int   nfail  = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: DEPTH=3, WIDTH=32, RESET_VAL=DEAD_BEEF
   logic        a_rst_n, a_valid, a_stall, a_flush, a_valid_o;
   logic [31:0] a_data, a_data_o;
   logic [1:0]  a_count_o;
   pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'hDEAD_BEEF)) u_a (
      .clk(clk), .rst_n(a_rst_n), .data_i(a_data), .valid_i(a_valid),
      .stall_i(a_stall), .flush_i(a_flush),
      .data_o(a_data_o), .valid_o(a_valid_o), .count_o(a_count_o));

   // Instance B: DEPTH=4, WIDTH=32, defaults
   logic        b_rst_n, b_valid, b_stall, b_flush, b_valid_o;
   logic [31:0] b_data, b_data_o;
   logic [2:0]  b_count_o;
   pipe_stage_reg #(.WIDTH(32), .DEPTH(4)) u_b (
      .clk(clk), .rst_n(b_rst_n), .data_i(b_data), .valid_i(b_valid),
      .stall_i(b_stall), .flush_i(b_flush),
      .data_o(b_data_o), .valid_o(b_valid_o), .count_o(b_count_o));

   // Instance C: DEPTH=1, WIDTH=8
   logic       c_rst_n, c_valid, c_stall, c_flush, c_valid_o;
   logic [7:0] c_data, c_data_o;
   logic [0:0] c_count_o;
   pipe_stage_reg #(.WIDTH(8), .DEPTH(1)) u_c (
      .clk(clk), .rst_n(c_rst_n), .data_i(c_data), .valid_i(c_valid),
      .stall_i(c_stall), .flush_i(c_flush),
      .data_o(c_data_o), .valid_o(c_valid_o), .count_o(c_count_o));

   task automatic push_exp(input int inst, input logic [31:0] ed, input logic ev,
                           input int ec, input string tag);
      exp_t e;
      e.cyc = cyc; e.inst = inst; e.d = ed; e.v = ev; e.c = ec; e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic a_step(input logic rst, input logic [31:0] d, input logic v, input logic st,
                         input logic fl, input logic [31:0] ed, input logic ev, input int ec,
                         input string tag);
      a_rst_n = rst; a_data = d; a_valid = v; a_stall = st; a_flush = fl;
      @(posedge clk); #1;
      push_exp(0, ed, ev, ec, tag);
   endtask

   task automatic b_step(input logic rst, input logic [31:0] d, input logic v,
                         input logic [31:0] ed, input logic ev, input int ec, input string tag);
      b_rst_n = rst; b_data = d; b_valid = v; b_stall = 1'b0; b_flush = 1'b0;
      @(posedge clk); #1;
      push_exp(1, ed, ev, ec, tag);
   endtask

   task automatic c_step(input logic rst, input logic [7:0] d, input logic v, input logic st,
                         input logic fl, input logic [7:0] ed, input logic ev, input int ec,
                         input string tag);
      c_rst_n = rst; c_data = d; c_valid = v; c_stall = st; c_flush = fl;
      @(posedge clk); #1;
      push_exp(2, {24'h0, ed}, ev, ec, tag);
   endtask

   // Monitor: compares every expectation tagged with the edge just taken.
   always @(negedge clk) begin
      while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
         logic [31:0] act_d;
         logic        act_v;
         logic [3:0]  act_c;
         mon_e = sb_q.pop_front();
         case (mon_e.inst)
            0:       begin act_d = a_data_o;         act_v = a_valid_o; act_c = {2'b00, a_count_o}; end
            1:       begin act_d = b_data_o;         act_v = b_valid_o; act_c = {1'b0, b_count_o};  end
            default: begin act_d = {24'h0, c_data_o}; act_v = c_valid_o; act_c = {3'b000, c_count_o}; end
         endcase
         ntests++;
         if (mon_e.cyc != cyc || act_d !== mon_e.d || act_v !== mon_e.v || act_c !== 4'(mon_e.c)) begin
            nfail++;
            $display("FAIL %s: got data=%h valid=%b count=%0d, expected data=%h valid=%b count=%0d (cycle %0d vs %0d)",
                     mon_e.tag, act_d, act_v, act_c, mon_e.d, mon_e.v, mon_e.c, cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst_n = 0; a_data = 0; a_valid = 0; a_stall = 0; a_flush = 0;
      b_rst_n = 0; b_data = 0; b_valid = 0; b_stall = 0; b_flush = 0;
      c_rst_n = 0; c_data = 0; c_valid = 0; c_stall = 0; c_flush = 0;

      // ---------------- Instance A ----------------
      a_step(0, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, "a_reset0");
      a_step(0, 32'h0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, "a_reset_over_flush");
      // Streaming 1..4
      a_step(1, 32'd1, 1, 0, 0, 32'hDEAD_BEEF, 0, 1, "a_str_e1");
      a_step(1, 32'd2, 1, 0, 0, 32'hDEAD_BEEF, 0, 2, "a_str_e2");
      a_step(1, 32'd3, 1, 0, 0, 32'd1, 1, 3, "a_str_e3");
      a_step(1, 32'd4, 1, 0, 0, 32'd2, 1, 3, "a_str_e4");
      a_step(1, 32'd0, 0, 0, 0, 32'd3, 1, 2, "a_str_e5");
      a_step(1, 32'd0, 0, 0, 0, 32'd4, 1, 1, "a_str_e6");
      a_step(1, 32'd0, 0, 0, 0, 32'd0, 0, 0, "a_str_e7");
      // Fill A,B,C then stall 4 cycles with FFFF_FFFF
      a_step(1, 32'hAAAA_0001, 1, 0, 0, 32'd0, 0, 1, "a_fill_a");
      a_step(1, 32'hBBBB_0002, 1, 0, 0, 32'd0, 0, 2, "a_fill_b");
      a_step(1, 32'hCCCC_0003, 1, 0, 0, 32'hAAAA_0001, 1, 3, "a_fill_c");
      for (int i = 0; i < 4; i++)
         a_step(1, 32'hFFFF_FFFF, 1, 1, 0, 32'hAAAA_0001, 1, 3, $sformatf("a_stall%0d", i));
      a_step(1, 32'h0, 0, 0, 0, 32'hBBBB_0002, 1, 2, "a_rel_b");
      a_step(1, 32'h0, 0, 0, 0, 32'hCCCC_0003, 1, 1, "a_rel_c");
      // Refill to full, then flush together with stall
      a_step(1, 32'hD, 1, 0, 0, 32'h0, 0, 1, "a_refill_d");
      a_step(1, 32'hE, 1, 0, 0, 32'h0, 0, 2, "a_refill_e");
      a_step(1, 32'hF, 1, 0, 0, 32'hD, 1, 3, "a_refill_f");
      a_step(1, 32'hFFFF_FFFF, 1, 1, 1, 32'h0000_0013, 0, 0, "a_flush_stall");
      a_step(1, 32'h77, 1, 0, 0, 32'h0000_0013, 0, 1, "a_postfl_e1");
      a_step(1, 32'h0, 0, 0, 0, 32'h0000_0013, 0, 1, "a_postfl_e2");
      a_step(1, 32'h0, 0, 0, 0, 32'h77, 1, 1, "a_postfl_e3");
      a_step(1, 32'h0, 0, 0, 0, 32'h0, 0, 0, "a_postfl_e4");
      // Reset during stall, then restart with no dead cycle
      a_step(1, 32'd1, 1, 0, 0, 32'h0, 0, 1, "a_pre_r1");
      a_step(1, 32'd2, 1, 0, 0, 32'h0, 0, 2, "a_pre_r2");
      a_step(1, 32'd3, 1, 0, 0, 32'd1, 1, 3, "a_pre_r3");
      a_step(1, 32'd9, 1, 1, 0, 32'd1, 1, 3, "a_pre_stall");
      a_step(0, 32'd9, 1, 1, 0, 32'hDEAD_BEEF, 0, 0, "a_rst_in_stall");
      a_step(1, 32'd7, 1, 0, 0, 32'hDEAD_BEEF, 0, 1, "a_post_r1");
      a_step(1, 32'd0, 0, 0, 0, 32'hDEAD_BEEF, 0, 1, "a_post_r2");
      a_step(1, 32'd0, 0, 0, 0, 32'd7, 1, 1, "a_post_r3");
      // X on data_i with valid_i=0 during flush must not reach the outputs
      a_step(1, 32'hxxxx_xxxx, 0, 0, 1, 32'h0000_0013, 0, 0, "a_x_flush");

      // ---------------- Instance B ----------------
      b_step(0, 32'h0, 0, 32'h0, 0, 0, "b_reset");
      b_step(1, 32'h10, 1, 32'h0,  0, 1, "b_alt_e1");
      b_step(1, 32'h11, 0, 32'h0,  0, 1, "b_alt_e2");
      b_step(1, 32'h12, 1, 32'h0,  0, 2, "b_alt_e3");
      b_step(1, 32'h13, 0, 32'h10, 1, 2, "b_alt_e4");
      b_step(1, 32'h14, 1, 32'h11, 0, 2, "b_alt_e5");
      b_step(1, 32'h15, 0, 32'h12, 1, 2, "b_alt_e6");
      b_step(1, 32'h16, 1, 32'h13, 0, 2, "b_alt_e7");
      b_step(1, 32'h17, 0, 32'h14, 1, 2, "b_alt_e8");
      b_step(1, 32'h0,  0, 32'h15, 0, 1, "b_drain_e9");
      b_step(1, 32'h0,  0, 32'h16, 1, 1, "b_drain_e10");
      b_step(1, 32'h0,  0, 32'h17, 0, 0, "b_drain_e11");
      b_step(1, 32'h0,  0, 32'h0,  0, 0, "b_drain_e12");
      // Fill to DEPTH and keep pushing: count saturates naturally at 4
      b_step(1, 32'h20, 1, 32'h0,  0, 1, "b_full_e1");
      b_step(1, 32'h21, 1, 32'h0,  0, 2, "b_full_e2");
      b_step(1, 32'h22, 1, 32'h0,  0, 3, "b_full_e3");
      b_step(1, 32'h23, 1, 32'h20, 1, 4, "b_full_e4");
      b_step(1, 32'h24, 1, 32'h21, 1, 4, "b_full_e5");

      // ---------------- Instance C ----------------
      c_step(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, "c_reset");
      c_step(1, 8'h5A, 1, 0, 0, 8'h5A, 1, 1, "c_5a");
      c_step(1, 8'h3C, 0, 0, 0, 8'h3C, 0, 0, "c_invalid");
      c_step(1, 8'hFF, 1, 1, 0, 8'h3C, 0, 0, "c_stall");
      c_step(1, 8'h81, 1, 0, 0, 8'h81, 1, 1, "c_81");
      c_step(1, 8'hFF, 1, 0, 1, 8'h13, 0, 0, "c_flush");

      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         nfail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
